// File: rtl/branch_pkg.sv
// Shared branch-op encodings, BHT counter states and the branch condition evaluator.
// Purely combinational helpers; no latency or flow control of their own.
package branch_pkg;

    localparam logic [4:0] BR_JUMP_BIT = 5'b1_0000;
    localparam logic [4:0] BR_BEQ      = 5'b0_1000;
    localparam logic [4:0] BR_BNE      = 5'b0_1001;
    localparam logic [4:0] BR_BLT      = 5'b0_1100;
    localparam logic [4:0] BR_BGE      = 5'b0_1101;
    localparam logic [4:0] BR_BLTU     = 5'b0_1110;
    localparam logic [4:0] BR_BGEU     = 5'b0_1111;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Operands are passed left-aligned at this width, which keeps both signed and
    // unsigned ordering intact for any XLEN up to BR_OPND_W.
    localparam int BR_OPND_W = 64;

    function automatic logic br_is_jump(input logic [4:0] op);
        return (op & BR_JUMP_BIT) != 5'b0;
    endfunction

    function automatic logic br_is_cond(input logic [4:0] op);
        return (op[4:3] == 2'b01) && (op[2:1] != 2'b01);
    endfunction

    function automatic logic br_eval(input logic [BR_OPND_W-1:0] data1,
                                     input logic [BR_OPND_W-1:0] data2,
                                     input logic [4:0]           op);
        logic taken;
        taken = 1'b0;
        if (br_is_jump(op)) begin
            taken = 1'b1;
        end else begin
            case (op)
                BR_BEQ:  taken = (data1 == data2);
                BR_BNE:  taken = (data1 != data2);
                BR_BLT:  taken = ($signed(data1) <  $signed(data2));
                BR_BGE:  taken = ($signed(data1) >= $signed(data2));
                BR_BLTU: taken = (data1 <  data2);
                BR_BGEU: taken = (data1 >= data2);
                default: taken = 1'b0;
            endcase
        end
        return taken;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters, reset to weak-not-taken.
// Combinational read with no bypass of a same-cycle update; update lands on the next edge.
module branch_bht
    import branch_pkg::*;
#(
    parameter  int BHT_DEPTH = 64,
    localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] cnt_q [BHT_DEPTH];
    logic [1:0] upd_cur;
    logic [1:0] upd_cnt_d;

    assign rd_taken = cnt_q[rd_idx][1];

    always_comb begin
        upd_cur   = cnt_q[upd_idx];
        upd_cnt_d = upd_cur;
        if (upd_taken && (upd_cur != CNT_ST)) begin
            upd_cnt_d = upd_cur + 2'd1;
        end else if (!upd_taken && (upd_cur != CNT_SNT)) begin
            upd_cnt_d = upd_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= upd_cnt_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver with BHT prediction; BRANCH_STATS_EN adds branch/mispredict counters.
// One-cycle registered result; res_ready = !out_valid | out_ready, holding the result under backpressure.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [4:0]      branchOp,
    input  logic            res_pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic [XLEN-1:0] out_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic                 accept;
    logic                 taken;
    logic                 mispredict;
    logic                 is_cond;
    logic                 is_jump;
    logic [BR_OPND_W-1:0] d1_al;
    logic [BR_OPND_W-1:0] d2_al;

    logic            out_valid_q, out_valid_d;
    logic            out_taken_q, out_taken_d;
    logic            out_mis_q,   out_mis_d;
    logic [XLEN-1:0] out_pc_q,    out_pc_d;

    // Only the index bits of pred_pc feed the table; fold the rest away explicitly.
    logic unused_pred_pc;
    assign unused_pred_pc = ^pred_pc;

    assign d1_al      = BR_OPND_W'(data1) << (BR_OPND_W - XLEN);
    assign d2_al      = BR_OPND_W'(data2) << (BR_OPND_W - XLEN);
    assign taken      = br_eval(d1_al, d2_al, branchOp);
    assign is_cond    = br_is_cond(branchOp);
    assign is_jump    = br_is_jump(branchOp);
    assign mispredict = taken ^ res_pred_taken;

    assign res_ready  = !out_valid_q || out_ready;
    assign accept     = res_valid && res_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_taken_d = out_taken_q;
        out_mis_d   = out_mis_q;
        out_pc_d    = out_pc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_taken_d = taken;
            out_mis_d   = mispredict;
            out_pc_d    = res_pc;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_mis_q   <= 1'b0;
            out_pc_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_taken_q <= out_taken_d;
            out_mis_q   <= out_mis_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = out_taken_q;
    assign out_mispredict = out_mis_q;
    assign out_pc         = out_pc_q;

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pred_pc[IDX_W+1:2]),
        .rd_taken  (pred_taken),
        .upd_en    (accept && is_cond),
        .upd_idx   (res_pc[IDX_W+1:2]),
        .upd_taken (taken)
    );

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q,  stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (accept && (is_cond || is_jump) && (stat_br_q != 32'hFFFF_FFFF)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (accept && mispredict && (stat_mis_q != 32'hFFFF_FFFF)) begin
            stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (stats ports when BRANCH_STATS_EN is defined).
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  branchOp;
    logic        res_pred_taken;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_mispredict;
    logic [31:0] out_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int passed = 0;

    localparam logic [4:0] OP_JAL  = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_NB0  = 5'b01010;
    localparam logic [4:0] OP_NB1  = 5'b01011;
    localparam logic [4:0] OP_NB2  = 5'b00000;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BGE  = 5'b01101;
    localparam logic [4:0] OP_BLTU = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;

    branch_predict_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_pc         (res_pc),
        .data1          (data1),
        .data2          (data2),
        .branchOp       (branchOp),
        .res_pred_taken (res_pred_taken),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_mispredict (out_mispredict),
        .out_pc         (out_pc)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pred(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        chk(tag, 32'(pred_taken), 32'(exp));
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic pt);
        branchOp       = op;
        data1          = a;
        data2          = b;
        res_pc         = pc;
        res_pred_taken = pt;
        res_valid      = 1'b1;
        tick();
        res_valid      = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic tk, input logic mis);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".taken"}, 32'(out_taken), 32'(tk));
        chk({tag, ".mis"}, 32'(out_mispredict), 32'(mis));
    endtask

    initial begin
        int ones;
        rst = 1'b1; pred_pc = '0; res_valid = 1'b0; res_pc = '0; data1 = '0; data2 = '0;
        branchOp = '0; res_pred_taken = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst.res_ready", 32'(res_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_taken", 32'(out_taken), 32'd0);
        chk("rst.out_mis", 32'(out_mispredict), 32'd0);
        chk("rst.out_pc", out_pc, 32'd0);
`ifdef BRANCH_STATS_EN
        chk("rst.stat_br", stat_branches, 32'd0);
        chk("rst.stat_mis", stat_mispredicts, 32'd0);
`endif
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            pred_pc = 32'(i * 4);
            #1;
            ones += int'(pred_taken);
        end
        chk("rst.sweep_ones", 32'(ones), 32'd0);

        // BEQ equal, guessed not taken: taken + mispredict, entry 0x40 goes 01->10
        tick();
        issue(OP_BEQ, 32'h1234, 32'h1234, 32'h40, 1'b0);
        chk_out("beq", 32'h40, 1'b1, 1'b1);
        chk_pred("beq.pred40", 32'h40, 1'b1);
        tick();
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // back-to-back compare sweep
        issue(OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h80, 1'b1);
        chk_out("blt", 32'h80, 1'b1, 1'b0);
        issue(OP_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h84, 1'b1);
        chk_out("bltu", 32'h84, 1'b0, 1'b1);
        issue(OP_BGE, 32'h8000_0000, 32'h0, 32'h88, 1'b0);
        chk_out("bge", 32'h88, 1'b0, 1'b0);
        issue(OP_BGEU, 32'h8000_0000, 32'h0, 32'h8C, 1'b0);
        chk_out("bgeu", 32'h8C, 1'b1, 1'b1);
        issue(OP_BNE, 32'h5, 32'h5, 32'h90, 1'b0);
        chk_out("bne", 32'h90, 1'b0, 1'b0);
        issue(OP_NB0, 32'h5, 32'h5, 32'h94, 1'b1);
        chk_out("nonbr", 32'h94, 1'b0, 1'b1);
        issue(OP_JAL, 32'h0, 32'h1, 32'h98, 1'b0);
        chk_out("jal", 32'h98, 1'b1, 1'b1);
        chk_pred("sweep.pred80", 32'h80, 1'b1);
        chk_pred("sweep.pred8c", 32'h8C, 1'b1);
        chk_pred("sweep.pred94", 32'h94, 1'b0);
        chk_pred("sweep.pred98", 32'h98, 1'b0);
        // 0x84 sits at 00 now; one taken only reaches 01
        issue(OP_BLT, 32'hFFFF_FFFF, 32'h1, 32'h84, 1'b0);
        chk_pred("snt.pred84", 32'h84, 1'b0);

        // saturation at entry 0 (pc 0x100)
        for (int i = 0; i < 4; i++) issue(OP_BEQ, 32'h7, 32'h7, 32'h100, 1'b1);
        chk_pred("sat.pred", 32'h100, 1'b1);
        issue(OP_BNE, 32'h7, 32'h7, 32'h100, 1'b1);
        chk_pred("sat.nt1", 32'h100, 1'b1);
        issue(OP_JAL, 32'h0, 32'h0, 32'h100, 1'b0);
        issue(OP_JAL, 32'h0, 32'h0, 32'h100, 1'b0);
        issue(OP_NB1, 32'h0, 32'h0, 32'h100, 1'b0);
        chk_pred("sat.nontrain", 32'h100, 1'b1);
        issue(OP_BNE, 32'h7, 32'h7, 32'h100, 1'b1);
        chk_pred("sat.nt2", 32'h100, 1'b0);

        // same-cycle read of an index being trained returns the old value
        tick();
        branchOp = OP_BEQ; data1 = 32'h9; data2 = 32'h9; res_pc = 32'h100;
        res_pred_taken = 1'b0; res_valid = 1'b1;
        chk_pred("nobypass.before", 32'h100, 1'b0);
        tick();
        res_valid = 1'b0;
        chk_pred("nobypass.after", 32'h100, 1'b1);

        // backpressure
        tick();
        out_ready = 1'b0;
        issue(OP_BEQ, 32'h1, 32'h1, 32'h200, 1'b1);
        chk_out("bp.a", 32'h200, 1'b1, 1'b0);
        branchOp = OP_BNE; data1 = 32'h1; data2 = 32'h2; res_pc = 32'h204;
        res_pred_taken = 1'b0; res_valid = 1'b1;
        #1;
        chk("bp.res_ready0", 32'(res_ready), 32'd0);
        tick();
        chk_out("bp.hold1", 32'h200, 1'b1, 1'b0);
        tick();
        chk_out("bp.hold2", 32'h200, 1'b1, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp.res_ready1", 32'(res_ready), 32'd1);
        tick();
        res_valid = 1'b0;
        chk_out("bp.b", 32'h204, 1'b1, 1'b1);
        // B trained exactly once (01->10), so one not-taken returns it to 01
        issue(OP_BEQ, 32'h1, 32'h2, 32'h204, 1'b0);
        chk_pred("bp.trained_once", 32'h204, 1'b0);

        // asynchronous reset with a result in flight
        issue(OP_JAL, 32'h0, 32'h0, 32'h300, 1'b0);
        chk("arst.pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.out_pc", out_pc, 32'd0);
        chk("arst.out_taken", 32'(out_taken), 32'd0);
        chk_pred("arst.pred80", 32'h80, 1'b0);
        chk_pred("arst.pred100", 32'h100, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst.res_ready", 32'(res_ready), 32'd1);
        tick();
        issue(OP_BEQ, 32'h3, 32'h3, 32'h80, 1'b0);
        chk_pred("arst.wnt_to_wt", 32'h80, 1'b1);

`ifdef BRANCH_STATS_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        chk("stat.zero_br", stat_branches, 32'd0);
        issue(OP_BEQ, 32'h3, 32'h3, 32'h10, 1'b1);
        issue(OP_JAL, 32'h0, 32'h0, 32'h14, 1'b1);
        issue(OP_BNE, 32'h3, 32'h3, 32'h18, 1'b1);
        issue(OP_NB2, 32'h0, 32'h0, 32'h1C, 1'b0);
        chk("stat.br3", stat_branches, 32'd3);
        chk("stat.mis1", stat_mispredicts, 32'd1);
        issue(OP_NB2, 32'h0, 32'h0, 32'h1C, 1'b1);
        chk("stat.br_nonbr", stat_branches, 32'd3);
        chk("stat.mis_nonbr", stat_mispredicts, 32'd2);
        rst = 1'b1;
        #1;
        chk("stat.rst_br", stat_branches, 32'd0);
        chk("stat.rst_mis", stat_mispredicts, 32'd0);
        rst = 1'b0;
`endif

        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator.
- Resolves branch/jump conditions on XLEN-wide operands behind a valid/ready input handshake.
- Registers the outcome with one cycle of latency and flags mispredictions against the fetch-time guess.
- Holds a BHT_DEPTH-entry table of 2-bit saturating counters that provides fetch-side predictions and trains on resolved conditional branches.

Parameters:
- XLEN, 32, operand and PC width.
- BHT_DEPTH, 64, number of BHT entries; power of two, >= 2. Derived localparam IDX_W = $clog2(BHT_DEPTH).

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- pred_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  prediction for pred_pc (combinational BHT read).
- res_valid  in  1  resolve request valid.
- res_ready  out  1  unit can accept a request.
- res_pc  in  XLEN  PC of the branch being resolved.
- data1  in  XLEN  first compare operand.
- data2  in  XLEN  second compare operand.
- branchOp  in  5  operation code.
- res_pred_taken  in  1  prediction that fetch used for this instruction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  resolved direction.
- out_mispredict  out  1  out_taken != prediction used.
- out_pc  out  XLEN  res_pc of the result.

Behaviour:
- branchOp decode:
  - 1xxxx: unconditional jump, taken = 1.
  - 01000 BEQ, 01001 BNE, 01100 BLT (signed), 01101 BGE (signed), 01110 BLTU, 01111 BGEU.
  - 01010, 01011, 00xxx: taken = 0, not a branch.
- Accept: accept = res_valid & res_ready. res_ready = !out_valid | out_ready, so back-to-back acceptance at full throughput is allowed.
- Output register:
  - On accept, load out_taken, out_pc and out_mispredict = taken ^ res_pred_taken. out_valid = 1 next cycle.
  - Otherwise, if out_ready, out_valid = 0.
  - Output fields are held stable while out_valid & !out_ready.
- Non-branch with res_pred_taken = 1 gives out_mispredict = 1. Jump with res_pred_taken = 0 gives out_mispredict = 1.
- BHT indexing:
  - idx = pc[IDX_W+1:2]; bits [1:0] are ignored.
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - pred_taken = bht[pred_pc idx][1].
- BHT training:
  - Only on accept of a conditional op (01xxx with a valid code).
  - Taken: increment, saturating at 11. Not taken: decrement, saturating at 00.
  - Jumps and non-branches never update the table.
- Same-cycle read/update of one index: pred_taken returns the pre-update value; there is no bypass.
- Reset (asynchronous, any time):
  - out_valid = 0, out_taken = 0, out_mispredict = 0, out_pc = 0.
  - All BHT entries = 01; stats counters = 0.
  - Any in-flight result is discarded.
  - res_ready = 1 while rst is low after reset.
- Signed and unsigned compares use the full XLEN width; no sign extension is involved.

Optional Feature:
- BRANCH_STATS_EN defined:
  - Adds output ports stat_branches (32) and stat_mispredicts (32).
  - stat_branches increments on every accepted jump or conditional op.
  - stat_mispredicts increments when an accepted instruction's mispredict = 1, including non-branches.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package branch_pkg holds:
  - 5-bit BrOp constants: BR_JUMP_BIT, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - 2-bit counter constants: CNT_SNT, CNT_WNT, CNT_WT, CNT_ST.
  - Pure function br_eval(data1, data2, op) returning taken.
- Sub-module branch_bht (parameters BHT_DEPTH):
  - Counter array, asynchronous-reset initialisation, combinational read port, saturating update port.
- Top level holds decode, handshake and output register.

Test Plan:
- Reset, then sweep pred_pc over 0x00..0xFC -> pred_taken = 0 for every entry; res_ready = 1, out_valid = 0.
- BEQ data1 = data2 = 0x1234, res_pred_taken = 0, out_ready = 1 -> next cycle out_taken = 1, out_mispredict = 1. BHT entry for res_pc = 0x40 goes 01→10, so pred_pc = 0x40 gives pred_taken = 1.
- BLT 0xFFFFFFFF vs 0x1 -> taken. BLTU with the same operands -> not taken. BGE 0x80000000 vs 0 -> not taken. BGEU 0x80000000 vs 0 -> taken.
- Same res_pc, taken conditional issued 4 times -> counter saturates at 11. Then 1 not-taken -> 10, pred_taken stays 1. Jump ops leave the entry unchanged.
- Hold out_ready = 0 with two consecutive requests -> first result held stable, res_ready = 0, second not accepted until out_ready = 1. Full throughput resumes with out_ready = 1.
- Assert rst mid-stream with out_valid = 1 -> out_valid drops immediately, BHT entries read 01. With BRANCH_STATS_EN, after 3 branches and 1 mispredict the counters read 3/1, and 0/0 after reset.
